// File: rtl/sc_stream_sched.sv
// sc_stream_sched: round-robin scheduler that time-shares one Sobol SC engine
// among N requesters. Each grant runs one full LEN-long stream, forwards it to
// the owner and reports how many ones it contained.
module sc_stream_sched #(
  parameter int N   = 4,
  parameter int W   = 6,
  parameter int LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   num_in,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic [N-1:0]     done,
  output logic [W:0]       ones_cnt,
  output logic             stream_bit,
  output logic             stream_valid,
  output logic             sc_start,
  output logic             sc_en,
  output logic [W-1:0]     sc_num,
  input  logic             sc_vld,
  input  logic             sc_bit
);

  localparam int         IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [W:0] LEN_C  = (W+1)'(LEN);
  localparam logic [W:0] LAST_C = (W+1)'(LEN - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          pick_valid;
  logic [N-1:0]  pick_onehot;
  logic [W:0]    en_cnt;
  logic [W:0]    vld_cnt;

  // Round-robin search: first requester above the last owner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_grant) + i) % N);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // One-hot form of the arbitration winner.
  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and state-decoded outputs; the engine enable stops after LEN cycles.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    sc_start   = (state == START);
    sc_en      = (state == RUN) && (en_cnt < LEN_C);
    done       = (state == DONE) ? grant : '0;
    case (state)
      IDLE:    if (pick_valid) state_next = START;
      START:   state_next = RUN;
      RUN:     if (sc_vld && (vld_cnt == LAST_C)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, target latch, stream counters and the forwarded bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      gnt_idx      <= '0;
      last_grant   <= IW'(N - 1);
      sc_num       <= '0;
      en_cnt       <= '0;
      vld_cnt      <= '0;
      ones_cnt     <= '0;
      stream_bit   <= 1'b0;
      stream_valid <= 1'b0;
    end else begin
      stream_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_onehot;
            gnt_idx <= pick_idx;
            sc_num  <= num_in[pick_idx*W +: W];
          end
        end
        START: begin
          ones_cnt <= '0;
          en_cnt   <= '0;
          vld_cnt  <= '0;
        end
        RUN: begin
          if (sc_en) en_cnt <= en_cnt + (W+1)'(1);
          if (sc_vld) begin
            vld_cnt      <= vld_cnt + (W+1)'(1);
            ones_cnt     <= ones_cnt + {{W{1'b0}}, sc_bit};
            stream_bit   <= sc_bit;
            stream_valid <= 1'b1;
          end
        end
        DONE: begin
          grant      <= '0;
          last_grant <= gnt_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_sched.sv
// tb_sc_stream_sched: directed bench for sc_stream_sched with a small engine model.
module tb_sc_stream_sched;

  localparam int N = 4;
  localparam int W = 6;
  localparam int LEN = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] num_in;
  logic [N-1:0]   grant;
  logic           busy;
  logic [N-1:0]   done;
  logic [W:0]     ones_cnt;
  logic           stream_bit;
  logic           stream_valid;
  logic           sc_start;
  logic           sc_en;
  logic [W-1:0]   sc_num;
  logic           sc_vld;
  logic           sc_bit;

  int checks = 0;
  int errors = 0;

  sc_stream_sched #(.N(N), .W(W), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .req(req), .num_in(num_in), .grant(grant), .busy(busy),
    .done(done), .ones_cnt(ones_cnt), .stream_bit(stream_bit), .stream_valid(stream_valid),
    .sc_start(sc_start), .sc_en(sc_en), .sc_num(sc_num), .sc_vld(sc_vld), .sc_bit(sc_bit)
  );

  always #5 clk = ~clk;

  // Engine model: one valid per accepted enable, one cycle later, with optional stall.
  logic eng_vld, eng_bit, vld_force, bit_force;
  int   pending, emitted, gap_done, pat_mode, gap_len;
  assign sc_vld = eng_vld | vld_force;
  assign sc_bit = eng_bit | bit_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_vld <= 1'b0; eng_bit <= 1'b0; pending <= 0; emitted <= 0; gap_done <= 0;
    end else if (sc_start) begin
      eng_vld <= 1'b0; pending <= 0; emitted <= 0; gap_done <= 0;
    end else if (emitted == 20 && gap_done < gap_len) begin
      eng_vld <= 1'b0; gap_done <= gap_done + 1; pending <= pending + (sc_en ? 1 : 0);
    end else if (pending > 0 || sc_en) begin
      eng_vld <= 1'b1;
      eng_bit <= (pat_mode == 0) ? 1'b1 : (pat_mode == 1) ? 1'b0 : ((emitted % 2) == 0);
      emitted <= emitted + 1;
      pending <= pending + (sc_en ? 1 : 0) - 1;
    end else begin
      eng_vld <= 1'b0;
    end
  end

  // Monitor: cumulative event counters sampled on the falling edge.
  int   cycle = 0;
  int   start_cnt = 0, en_seen = 0, sv_cnt = 0, sv_ones = 0, done_cnt = 0, bit_err = 0;
  int   start_time = 0, done_time = 0;
  logic prev_bit = 1'b0;

  always @(posedge clk) begin
    cycle    <= cycle + 1;
    prev_bit <= sc_bit;
  end

  always @(negedge clk) begin
    if (sc_start) begin start_cnt++; start_time = cycle; end
    if (sc_en) en_seen++;
    if (stream_valid) begin
      sv_cnt++;
      if (stream_bit) sv_ones++;
      if (stream_bit !== prev_bit) bit_err++;
    end
    if (done != '0) begin done_cnt++; done_time = cycle; end
  end

  // Results of the most recent run_stream call.
  logic [N-1:0] r_grant, r_done, r_done_grant, r_grant_after;
  logic [W-1:0] r_num, r_num_end;
  logic [W:0]   r_ones;
  logic         r_start, r_busy_after, r_grant_ok, r_done_ok;
  int           r_starts, r_ens, r_svs, r_sv_ones, r_dones, r_lat, r_berr;

  // Requests r, waits for the grant, scrambles num_in, waits for done and collects deltas.
  task automatic run_stream(input logic [N-1:0] r, input int mode_v, input int gap_v, input logic drop);
    int b_start, b_en, b_sv, b_ones, b_done, b_berr;
    pat_mode = mode_v;
    gap_len  = gap_v;
    #1;
    b_start = start_cnt; b_en = en_seen; b_sv = sv_cnt; b_ones = sv_ones; b_done = done_cnt; b_berr = bit_err;
    req = r;
    r_grant_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant != '0) begin r_grant_ok = 1'b1; break; end
    end
    r_grant = grant; r_num = sc_num; r_start = sc_start;
    num_in = ~num_in;
    if (drop) req = '0;
    r_done_ok = 1'b0; r_done = '0; r_done_grant = '0; r_num_end = '0;
    if (r_grant_ok) begin
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (done != '0) begin
          r_done_ok = 1'b1; r_done = done; r_done_grant = grant; r_num_end = sc_num;
          break;
        end
      end
    end
    req = '0;
    @(negedge clk);
    r_grant_after = grant; r_busy_after = busy;
    #1;
    r_starts = start_cnt - b_start; r_ens = en_seen - b_en; r_svs = sv_cnt - b_sv;
    r_sv_ones = sv_ones - b_ones; r_dones = done_cnt - b_done; r_berr = bit_err - b_berr;
    r_lat = done_time - start_time;
    r_ones = ones_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; num_in = '0; vld_force = 1'b0; bit_force = 1'b0; pat_mode = 0; gap_len = 0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL rst_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 4'b0000) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0000", done); end
    checks++; if (ones_cnt !== 7'd0) begin errors++; $display("[TB] FAIL rst_ones: got %0d expected 0", ones_cnt); end
    checks++; if ({stream_valid, stream_bit, sc_start, sc_en} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ctl: got %b expected 0000", {stream_valid, stream_bit, sc_start, sc_en}); end
    checks++; if (sc_num !== 6'd0) begin errors++; $display("[TB] FAIL rst_num: got %0d expected 0", sc_num); end
    rst = 1'b0;
    vld_force = 1'b1; bit_force = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_vld_ignored: got %b expected 0", stream_valid); end
    checks++; if (ones_cnt !== 7'd0) begin errors++; $display("[TB] FAIL idle_vld_count: got %0d expected 0", ones_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    vld_force = 1'b0; bit_force = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_stream();
    num_in = {6'd9, 6'd8, 6'd7, 6'd51};
    run_stream(4'b0001, 0, 0, 1'b0);
    checks++; if (!r_grant_ok || r_grant !== 4'b0001) begin errors++; $display("[TB] FAIL t1_grant: got %b expected 0001", r_grant); end
    checks++; if (r_start !== 1'b1) begin errors++; $display("[TB] FAIL t1_start_latency: got %b expected 1", r_start); end
    checks++; if (r_num !== 6'd51) begin errors++; $display("[TB] FAIL t1_sc_num: got %0d expected 51", r_num); end
    checks++; if (!r_done_ok || r_done !== 4'b0001) begin errors++; $display("[TB] FAIL t1_done: got %b expected 0001", r_done); end
    checks++; if (r_done_grant !== 4'b0001) begin errors++; $display("[TB] FAIL t1_grant_at_done: got %b expected 0001", r_done_grant); end
    checks++; if (r_num_end !== 6'd51) begin errors++; $display("[TB] FAIL t1_num_latched: got %0d expected 51", r_num_end); end
    checks++; if (r_starts != 1) begin errors++; $display("[TB] FAIL t1_start_pulses: got %0d expected 1", r_starts); end
    checks++; if (r_ens != 64) begin errors++; $display("[TB] FAIL t1_en_cycles: got %0d expected 64", r_ens); end
    checks++; if (r_svs != 64) begin errors++; $display("[TB] FAIL t1_valid_pulses: got %0d expected 64", r_svs); end
    checks++; if (r_ones !== 7'd64) begin errors++; $display("[TB] FAIL t1_ones_cnt: got %0d expected 64", r_ones); end
    checks++; if (r_dones != 1) begin errors++; $display("[TB] FAIL t1_done_pulses: got %0d expected 1", r_dones); end
    checks++; if (r_lat != 66) begin errors++; $display("[TB] FAIL t1_done_latency: got %0d expected 66", r_lat); end
    checks++; if (r_grant_after !== 4'b0000 || r_busy_after !== 1'b0) begin errors++; $display("[TB] FAIL t1_idle_after: got grant %b busy %b expected 0000 0", r_grant_after, r_busy_after); end
  endtask

  task automatic test_bit_patterns();
    num_in = {6'd1, 6'd2, 6'd3, 6'd20};
    run_stream(4'b0001, 1, 0, 1'b0);
    checks++; if (r_ones !== 7'd0) begin errors++; $display("[TB] FAIL t2_zero_ones: got %0d expected 0", r_ones); end
    checks++; if (r_sv_ones != 0 || r_svs != 64) begin errors++; $display("[TB] FAIL t2_zero_stream: got ones %0d valids %0d expected 0 64", r_sv_ones, r_svs); end
    checks++; if (r_berr != 0) begin errors++; $display("[TB] FAIL t2_zero_bit_delay: got %0d bad bits expected 0", r_berr); end
    num_in = {6'd1, 6'd2, 6'd3, 6'd20};
    run_stream(4'b0001, 2, 0, 1'b0);
    checks++; if (r_ones !== 7'd32) begin errors++; $display("[TB] FAIL t2_alt_ones: got %0d expected 32", r_ones); end
    checks++; if (r_sv_ones != 32 || r_svs != 64) begin errors++; $display("[TB] FAIL t2_alt_stream: got ones %0d valids %0d expected 32 64", r_sv_ones, r_svs); end
    checks++; if (r_berr != 0) begin errors++; $display("[TB] FAIL t2_alt_bit_delay: got %0d bad bits expected 0", r_berr); end
  endtask

  task automatic test_vld_gap();
    num_in = {6'd4, 6'd3, 6'd2, 6'd33};
    run_stream(4'b0001, 0, 10, 1'b0);
    checks++; if (r_ens != 64) begin errors++; $display("[TB] FAIL t4_en_cycles: got %0d expected 64", r_ens); end
    checks++; if (r_lat != 76) begin errors++; $display("[TB] FAIL t4_done_latency: got %0d expected 76", r_lat); end
    checks++; if (r_ones !== 7'd64) begin errors++; $display("[TB] FAIL t4_ones_cnt: got %0d expected 64", r_ones); end
    checks++; if (!r_done_ok || r_done !== 4'b0001) begin errors++; $display("[TB] FAIL t4_done: got %b expected 0001", r_done); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_g;
    logic [W-1:0] exp_n;
    logic         ok;
    rst = 1'b1; pat_mode = 0; gap_len = 0;
    req = 4'b0101;
    num_in = {6'd5, 6'd40, 6'd22, 6'd13};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_n = (k % 2 == 0) ? 6'd13 : 6'd40;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (grant != '0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || grant !== exp_g) begin errors++; $display("[TB] FAIL t3_grant%0d: got %b expected %b", k, grant, exp_g); end
      checks++; if (sc_num !== exp_n) begin errors++; $display("[TB] FAIL t3_num%0d: got %0d expected %0d", k, sc_num, exp_n); end
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (done != '0) begin ok = 1'b1; break; end
      end
      if (k == 3) req = '0;
      checks++; if (!ok || done !== exp_g) begin errors++; $display("[TB] FAIL t3_done%0d: got %b expected %b", k, done, exp_g); end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    num_in = {6'd1, 6'd2, 6'd17, 6'd3};
    run_stream(4'b0010, 2, 0, 1'b1);
    checks++; if (r_grant !== 4'b0010) begin errors++; $display("[TB] FAIL t6_grant: got %b expected 0010", r_grant); end
    checks++; if (r_num !== 6'd17 || r_num_end !== 6'd17) begin errors++; $display("[TB] FAIL t6_num: got %0d/%0d expected 17", r_num, r_num_end); end
    checks++; if (!r_done_ok || r_done !== 4'b0010) begin errors++; $display("[TB] FAIL t6_done: got %b expected 0010", r_done); end
    checks++; if (r_ones !== 7'd32) begin errors++; $display("[TB] FAIL t6_ones_cnt: got %0d expected 32", r_ones); end
    checks++; if (r_busy_after !== 1'b0 || r_grant_after !== 4'b0000) begin errors++; $display("[TB] FAIL t6_idle_after: got busy %b grant %b expected 0 0000", r_busy_after, r_grant_after); end
  endtask

  task automatic test_reset_mid_run();
    logic ok;
    int   b_done;
    pat_mode = 0; gap_len = 0;
    num_in = {6'd8, 6'd7, 6'd6, 6'd5};
    req = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || grant !== 4'b0100) begin errors++; $display("[TB] FAIL t5_first_grant: got %b expected 0100", grant); end
    repeat (20) @(negedge clk);
    checks++; if (sc_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL t5_mid_run: got en %b busy %b expected 1 1", sc_en, busy); end
    #1;
    b_done = done_cnt;
    rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || done !== 4'b0000) begin errors++; $display("[TB] FAIL t5_async_grant: got %b/%b expected 0000/0000", grant, done); end
    checks++; if ({busy, sc_en, sc_start, stream_valid} !== 4'b0000) begin errors++; $display("[TB] FAIL t5_async_ctl: got %b expected 0000", {busy, sc_en, sc_start, stream_valid}); end
    checks++; if (ones_cnt !== 7'd0 || sc_num !== 6'd0) begin errors++; $display("[TB] FAIL t5_async_data: got ones %0d num %0d expected 0 0", ones_cnt, sc_num); end
    req = 4'b1001;
    num_in = {6'd44, 6'd7, 6'd6, 6'd29};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || grant !== 4'b0001) begin errors++; $display("[TB] FAIL t5_grant_after_reset: got %b expected 0001", grant); end
    checks++; if (sc_num !== 6'd29) begin errors++; $display("[TB] FAIL t5_num_after_reset: got %0d expected 29", sc_num); end
    #1;
    checks++; if (done_cnt != b_done) begin errors++; $display("[TB] FAIL t5_no_done: got %0d pulses expected 0", done_cnt - b_done); end
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done != '0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || done !== 4'b0001) begin errors++; $display("[TB] FAIL t5_done_after_reset: got %b expected 0001", done); end
    @(negedge clk);
    checks++; if (ones_cnt !== 7'd64) begin errors++; $display("[TB] FAIL t5_ones_after_reset: got %0d expected 64", ones_cnt); end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_single_stream();
    test_bit_patterns();
    test_vld_gap();
    test_back_to_back();
    test_req_drop();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog in case the sequence itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
